// File: rtl/nibble_word_assembler_pkg.sv
// Shared types and constants for the nibble-serial to word-parallel assembler.
package nibble_word_assembler_pkg;

    localparam int NIBBLE_W         = 4;
    localparam int CNT_SIZE_DEFAULT = 3;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        FULL
    } asm_state_t;

endpackage

// File: rtl/nibble_word_assembler_if.sv
// Nibble-in / word-out handshake bundle; slave is the assembler, master the environment.
interface nibble_word_assembler_if
    import nibble_word_assembler_pkg::*;
#(
    parameter int CNT_SIZE = CNT_SIZE_DEFAULT
) ();

    localparam int WORD_W = NIBBLE_W * (2 ** CNT_SIZE);

    logic                nib_valid;
    logic                nib_ready;
    logic [NIBBLE_W-1:0] nib_data;
    logic                msb_first;
    logic [CNT_SIZE-1:0] len;
    logic                word_valid;
    logic                word_ready;
    logic [WORD_W-1:0]   word;
    logic                busy;

    modport slave (
        input  nib_valid, nib_data, msb_first, len, word_ready,
        output nib_ready, word_valid, word, busy
    );

    modport master (
        output nib_valid, nib_data, msb_first, len, word_ready,
        input  nib_ready, word_valid, word, busy
    );

endinterface

// File: rtl/nibble_word_assembler_nibble_demux.sv
// Replaces one nibble of a word, selected by index; all other nibbles pass through.
module nibble_demux
    import nibble_word_assembler_pkg::*;
#(
    parameter int SEL_W  = CNT_SIZE_DEFAULT,
    parameter int WORD_W = NIBBLE_W * (2 ** SEL_W)
) (
    input  logic [WORD_W-1:0]   word_i,
    input  logic [SEL_W-1:0]    sel_i,
    input  logic [NIBBLE_W-1:0] nib_i,
    output logic [WORD_W-1:0]   word_o
);

    // NOTE: default the whole output first so the partial write cannot infer a latch.
    always_comb begin
        word_o = word_i;
        word_o[int'(sel_i) * NIBBLE_W +: NIBBLE_W] = nib_i;
    end

endmodule

// File: rtl/nibble_word_assembler.sv
// Assembles LSB- or MSB-first nibble streams of 1..2**CNT_SIZE nibbles into one word,
// with a one-word output register so a new word can fill while the previous one waits.
module nibble_word_assembler
    import nibble_word_assembler_pkg::*;
#(
    parameter int CNT_SIZE = CNT_SIZE_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    nibble_word_assembler_if.slave   bus
);

    localparam int WORD_W = NIBBLE_W * (2 ** CNT_SIZE);
    localparam logic [CNT_SIZE-1:0] IDX_ONE = CNT_SIZE'(1);

    asm_state_t          state_q, state_d;
    logic [CNT_SIZE-1:0] idx_q, idx_d;
    logic [CNT_SIZE-1:0] len_q, len_d;
    logic                msb_q, msb_d;
    logic [WORD_W-1:0]   asm_q, asm_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic                word_valid_q, word_valid_d;

    logic                nib_fire;
    logic                word_fire;
    logic [CNT_SIZE-1:0] cur_idx;
    logic [CNT_SIZE-1:0] cur_len;
    logic                cur_msb;
    logic [WORD_W-1:0]   asm_base;
    logic [WORD_W-1:0]   asm_wr;
    logic                is_last;

    assign bus.nib_ready  = !rst && (state_q != FULL);
    assign bus.word_valid = word_valid_q;
    assign bus.word       = word_q;
    assign bus.busy       = (state_q != IDLE);

    assign nib_fire  = bus.nib_valid && bus.nib_ready;
    assign word_fire = word_valid_q && bus.word_ready;

    // A word start takes order/length straight from the bus; later nibbles use the latched copy.
    assign cur_msb  = (state_q == IDLE) ? bus.msb_first : msb_q;
    assign cur_len  = (state_q == IDLE) ? bus.len : len_q;
    assign cur_idx  = (state_q == IDLE) ? (bus.msb_first ? bus.len : '0) : idx_q;
    assign asm_base = (state_q == IDLE) ? '0 : asm_q;
    assign is_last  = cur_msb ? (cur_idx == '0) : (cur_idx == cur_len);

    nibble_demux #(
        .SEL_W  (CNT_SIZE),
        .WORD_W (WORD_W)
    ) u_demux (
        .word_i (asm_base),
        .sel_i  (cur_idx),
        .nib_i  (bus.nib_data),
        .word_o (asm_wr)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        len_d        = len_q;
        msb_d        = msb_q;
        asm_d        = asm_q;
        word_d       = word_q;
        word_valid_d = word_fire ? 1'b0 : word_valid_q;

        case (state_q)
            IDLE, FILL: begin
                if (nib_fire) begin
                    msb_d = cur_msb;
                    len_d = cur_len;
                    asm_d = asm_wr;
                    if (is_last) begin
                        // Output register is free now, or frees on this very edge.
                        if (!word_valid_q || word_fire) begin
                            word_d       = asm_wr;
                            word_valid_d = 1'b1;
                            state_d      = IDLE;
                        end else begin
                            state_d = FULL;
                        end
                    end else begin
                        idx_d   = cur_msb ? (cur_idx - IDX_ONE) : (cur_idx + IDX_ONE);
                        state_d = FILL;
                    end
                end
            end
            FULL: begin
                if (word_fire) begin
                    word_d       = asm_q;
                    word_valid_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            len_q        <= '0;
            msb_q        <= 1'b0;
            asm_q        <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            len_q        <= len_d;
            msb_q        <= msb_d;
            asm_q        <= asm_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
        end
    end

endmodule

// File: tb/tb_nibble_word_assembler.sv
// Directed bench for nibble_word_assembler: ordering, length, latency, backpressure and reset.
module tb_nibble_word_assembler;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   t0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nibble_word_assembler_if #(.CNT_SIZE(3)) bus ();

    nibble_word_assembler #(.CNT_SIZE(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called and returns 1ns after a rising edge; the nibble is taken on the first edge with nib_ready.
    task automatic send_nib(input logic [3:0] d, input logic m, input logic [2:0] l);
        int guard = 0;
        bus.nib_valid = 1'b1;
        bus.nib_data  = d;
        bus.msb_first = m;
        bus.len       = l;
        while (!bus.nib_ready && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 50) check("nib_ready_timeout", 32'(guard), 32'd0);
        @(posedge clk);
        #1;
        bus.nib_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        bus.nib_valid  = 1'b0;
        bus.nib_data   = '0;
        bus.msb_first  = 1'b0;
        bus.len        = '0;
        bus.word_ready = 1'b1;
        tick();
        check("rst_nib_ready", 32'(bus.nib_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_nib_ready", 32'(bus.nib_ready), 32'd1);
        check("post_rst_word_valid", 32'(bus.word_valid), 32'd0);
        check("post_rst_word", bus.word, 32'h0);
        check("post_rst_busy", 32'(bus.busy), 32'd0);
        tick();

        // LSB-first full word, checking one-cycle latency
        for (int i = 1; i <= 7; i++) send_nib(4'(i), 1'b0, 3'd7);
        check("lsb_busy_mid", 32'(bus.busy), 32'd1);
        check("lsb_valid_early", 32'(bus.word_valid), 32'd0);
        send_nib(4'h8, 1'b0, 3'd7);
        check("lsb_valid", 32'(bus.word_valid), 32'd1);
        check("lsb_word", bus.word, 32'h8765_4321);
        check("lsb_busy_done", 32'(bus.busy), 32'd0);

        // MSB-first full word
        send_nib(4'hF, 1'b1, 3'd7);
        for (int i = 0; i < 6; i++) send_nib(4'h0, 1'b1, 3'd7);
        send_nib(4'h1, 1'b1, 3'd7);
        check("msb_valid", 32'(bus.word_valid), 32'd1);
        check("msb_word", bus.word, 32'hF000_0001);

        // Short MSB-first word then a one-nibble word with no bubble
        send_nib(4'hA, 1'b1, 3'd2);
        send_nib(4'hB, 1'b1, 3'd2);
        send_nib(4'hC, 1'b1, 3'd2);
        check("short_word", bus.word, 32'h0000_0ABC);
        t0 = cyc;
        send_nib(4'h5, 1'b0, 3'd0);
        check("len0_word", bus.word, 32'h0000_0005);
        check("len0_valid", 32'(bus.word_valid), 32'd1);
        check("len0_no_bubble", 32'(cyc - t0), 32'd1);
        tick();
        check("drained_valid", 32'(bus.word_valid), 32'd0);

        // Backpressure: second word parks in FULL while first is held
        bus.word_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_nib(4'h1, 1'b0, 3'd7);
        for (int i = 0; i < 8; i++) send_nib(4'h2, 1'b0, 3'd7);
        check("bp_nib_ready", 32'(bus.nib_ready), 32'd0);
        check("bp_busy", 32'(bus.busy), 32'd1);
        check("bp_word", bus.word, 32'h1111_1111);
        tick();
        tick();
        check("bp_hold_word", bus.word, 32'h1111_1111);
        check("bp_hold_valid", 32'(bus.word_valid), 32'd1);
        bus.word_ready = 1'b1;
        #1;
        check("bp_first_out", bus.word, 32'h1111_1111);
        tick();
        check("bp_second_out", bus.word, 32'h2222_2222);
        check("bp_second_valid", 32'(bus.word_valid), 32'd1);
        check("bp_nib_ready_back", 32'(bus.nib_ready), 32'd1);
        tick();
        check("bp_drained", 32'(bus.word_valid), 32'd0);

        // Reset with a pending word and a partial word
        bus.word_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_nib(4'h3, 1'b0, 3'd7);
        for (int i = 0; i < 3; i++) send_nib(4'h4, 1'b0, 3'd7);
        rst = 1'b1;
        #1;
        check("mid_rst_nib_ready", 32'(bus.nib_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("rst2_word_valid", 32'(bus.word_valid), 32'd0);
        check("rst2_word", bus.word, 32'h0);
        check("rst2_busy", 32'(bus.busy), 32'd0);
        bus.word_ready = 1'b1;
        for (int i = 0; i < 8; i++) send_nib(4'(i), 1'b0, 3'd7);
        check("rst2_after_word", bus.word, 32'h7654_3210);
        check("rst2_after_valid", 32'(bus.word_valid), 32'd1);

        // Order/length toggling mid-word must be ignored
        send_nib(4'h9, 1'b0, 3'd7);
        for (int i = 1; i < 8; i++)
            send_nib(4'(9 - i), (i % 2) == 1, ((i % 2) == 1) ? 3'd0 : 3'd7);
        check("toggle_word", bus.word, 32'h2345_6789);
        check("toggle_valid", 32'(bus.word_valid), 32'd1);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
